v810_exc_ctrl: RTL and testbench
================================

Name: v810_exc_ctrl

Overview:
- Exception/interrupt sequencer and system-register owner for the V810 core.
- Holds EIPC, EIPSW, FEPC, FEPSW, ECR, PSW and CHCW, and serves LDSR/STSR accesses.
- Sequences exception, NMI, interrupt entry and RETI, and hands the core a redirect PC through a valid/ack handshake.
- Enters a halted state on a fatal (third-level) exception.

Parameters:
- PIR_VALUE, 32'h0000_8100, value returned on reads of PIR.
- TKCW_VALUE, 32'h0000_00E0, value returned on reads of TKCW.

Ports:
- CLK  in  1  core clock; one clock domain.
- RST  in  1  asynchronous, active-high reset.
- exc_req  in  1  synchronous trap/exception strobe, 1 cycle.
- exc_code  in  16  exception code for exc_req.
- exc_pc  in  32  restart PC for exc_req.
- cur_pc  in  32  restart PC for NMI/interrupt.
- nmi  in  1  NMI pin, rising-edge detected.
- irq_req  in  1  maskable interrupt request, level.
- irq_lvl  in  4  requested interrupt level.
- reti  in  1  RETI strobe.
- fetch_pc  in  32  current fetch address (address trap only).
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  new PC for the core.
- redirect_ack  in  1  core accepted the redirect.
- busy  out  1  state is not IDLE.
- halt  out  1  fatal exception; sticky until RST.
- psw  out  32  current PSW (psw_t layout).
- sr_sel  in  5  system-register select (sr_sel_t encoding).
- sr_we  in  1  LDSR write strobe.
- sr_wdata  in  32  LDSR data.
- sr_rdata  out  32  STSR data; combinational from sr_sel.

Behaviour:
- Reset values: PSW=32'h0000_8000 (NP=1), ECR=32'h0000_FFF0, EIPC/EIPSW/FEPC/FEPSW=0, CHCW=0, redirect_valid=0, redirect_pc=32'hFFFF_FFF0, busy=0, halt=0, state=IDLE.
- States: IDLE, REDIRECT, FATAL.
- Event accepted in cycle N from IDLE: all register updates occur on the edge ending N. State goes to REDIRECT and redirect_valid is high from N+1. It stays high, with redirect_pc stable, until a cycle where redirect_ack=1; the state returns to IDLE on that edge. Ack is ignored outside REDIRECT.
- Events are sampled only in IDLE. Priority: exc_req > nmi edge > irq > reti. Lower-priority events in the same cycle are dropped, except the NMI edge, which is latched pending until serviced.
- IRQ is accepted only if PSW.ID=0, EP=0, NP=0 and irq_lvl >= PSW.I.
- Entry with NP=1 (any exception): go to FATAL; halt=1; no register updates. FATAL is exited only by RST.
- Entry with EP=1, or NMI: FEPC<=pc, FEPSW<=PSW, ECR.FECC<=code (NMI code 16'hFFD0), PSW.NP<=1, ID<=1, AE<=0. Vector: NMI 32'hFFFF_FFD0; duplexed 32'hFFFF_FFD0.
- Other entry: EIPC<=pc, EIPSW<=PSW, ECR.EICC<=code, PSW.EP<=1, ID<=1, AE<=0. For an IRQ: code=16'hFE00|{irq_lvl,4'h0} and PSW.I<=min(irq_lvl+1,15). Vector = 32'hFFFF_0000 | {code[15:4],4'h0}.
- RETI: if NP, PC<=FEPC and PSW<=FEPSW; else PC<=EIPC and PSW<=EIPSW. Target goes out through REDIRECT.
- LDSR: honored only in IDLE with no event accepted that cycle; otherwise dropped.
  - PSW writes mask bits [31:20] and [11:10] to 0.
  - EIPC/FEPC bit0 forced 0.
  - ECR, PIR and TKCW are read-only.
  - Unlisted selects: writes ignored, reads 0.
- STSR reads reflect register state before any same-cycle write.
- psw output is registered PSW (no bypass).

Optional Feature:
- Macro V810_ADTRE_EN.
- Defined: ADTRE register is implemented (R/W, bit0 forced 0, reset 0). When PSW.AE=1 and fetch_pc==ADTRE in IDLE, an address-trap exception is raised with code 16'hFFC0, pc=fetch_pc, and priority just below exc_req.
- Undefined: ADTRE reads 0, writes are ignored, and fetch_pc is unused.

Test Plan:
- Reset, then STSR PSW/ECR/PIR -> 32'h0000_8000 / 32'h0000_FFF0 / 32'h0000_8100; halt=0.
- LDSR PSW=0; irq_req=1, irq_lvl=3, cur_pc=32'h0700_0010 -> next cycle redirect_valid=1, redirect_pc=32'hFFFF_FE30, EIPC=32'h0700_0010, ECR.EICC=16'hFE30, PSW.I=4, EP=1, ID=1. Hold ack low 3 cycles -> valid/pc stable; busy=1.
- From the previous state, reti -> redirect_pc=32'h0700_0010, PSW=0.
- PSW.EP=1, exc_req code 16'hFF60 -> FEPC updated, FECC=16'hFF60, NP=1, redirect_pc=32'hFFFF_FFD0. A second exc_req -> halt=1; state stays FATAL until RST.
- Same cycle: exc_req + nmi rising edge + irq -> exc_req serviced first; after ack, NMI serviced; IRQ blocked (ID=1).
- LDSR PSW=32'hFFFF_FFFF -> reads 32'h000F_F3FF. Assert RST while redirect_valid=1 -> outputs return to reset values immediately.

Source files
------------

// File: rtl/v810_exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : v810_exc_ctrl_if
// Purpose  : Bundles every signal between the V810 core pipeline and the
//            exception/system-register controller.
//   master : core side. Drives the event strobes, restart PCs, redirect_ack
//            and the LDSR/STSR access.
//   slave  : controller side. Drives redirect_valid/redirect_pc, busy, halt,
//            psw and sr_rdata.
// Revision : 1.0 - initial release
// ============================================================================
interface v810_exc_ctrl_if;
    // Event inputs
    logic        exc_req;
    logic [15:0] exc_code;
    logic [31:0] exc_pc;
    logic [31:0] cur_pc;
    logic        nmi;
    logic        irq_req;
    logic [3:0]  irq_lvl;
    logic        reti;
    logic [31:0] fetch_pc;
    // Redirect handshake
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    // Status
    logic        busy;
    logic        halt;
    logic [31:0] psw;
    // System-register access
    logic [4:0]  sr_sel;
    logic        sr_we;
    logic [31:0] sr_wdata;
    logic [31:0] sr_rdata;

    modport master (
        output exc_req, exc_code, exc_pc, cur_pc, nmi, irq_req, irq_lvl,
               reti, fetch_pc, redirect_ack, sr_sel, sr_we, sr_wdata,
        input  redirect_valid, redirect_pc, busy, halt, psw, sr_rdata
    );

    modport slave (
        input  exc_req, exc_code, exc_pc, cur_pc, nmi, irq_req, irq_lvl,
               reti, fetch_pc, redirect_ack, sr_sel, sr_we, sr_wdata,
        output redirect_valid, redirect_pc, busy, halt, psw, sr_rdata
    );
endinterface
`default_nettype wire

// File: rtl/v810_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : v810_exc_ctrl
// Purpose  : Exception/interrupt sequencer and system-register owner for the
//            V810 core.
//            Holds EIPC, EIPSW, FEPC, FEPSW, ECR, PSW and CHCW, and serves
//            LDSR/STSR.
//            Sequences exception, NMI, interrupt entry and RETI, and hands
//            the core a redirect PC through a valid/ack handshake.
//            A fatal (third-level) exception enters a halted state.
// Ports    : clk, rst (asynchronous, active high)
//            bus (v810_exc_ctrl_if.slave): event inputs, redirect handshake,
//            status outputs and system-register access.
// Options  : define V810_ADTRE_EN to implement ADTRE and the address trap.
// Revision : 1.0 - initial release
// ============================================================================
module v810_exc_ctrl #(
    parameter logic [31:0] PIR_VALUE  = 32'h0000_8100,
    parameter logic [31:0] TKCW_VALUE = 32'h0000_00E0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    v810_exc_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FATAL    = 2'd2
    } state_t;

    typedef enum logic [4:0] {
        SR_EIPC  = 5'd0,  SR_EIPSW = 5'd1,  SR_FEPC = 5'd2,  SR_FEPSW = 5'd3,
        SR_ECR   = 5'd4,  SR_PSW   = 5'd5,  SR_PIR  = 5'd6,  SR_TKCW  = 5'd7,
        SR_CHCW  = 5'd24, SR_ADTRE = 5'd25
    } sr_sel_t;

    // PSW bit positions
    localparam int c_PSW_ID = 12;
    localparam int c_PSW_AE = 13;
    localparam int c_PSW_EP = 14;
    localparam int c_PSW_NP = 15;
    // PSW bits [31:20] and [11:10] do not exist and always read 0
    localparam logic [31:0] c_PSW_MASK = 32'h000F_F3FF;
    localparam logic [31:0] c_DUP_VEC  = 32'hFFFF_FFD0;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_eipc, r_eipsw, r_fepc, r_fepsw, r_ecr, r_psw, r_chcw;
    logic [31:0] r_redirect_pc;
    logic        r_nmi_prev, r_nmi_pend;

    logic        w_nmi_pend, w_irq_ok, w_atrap;
    logic        w_take_exc, w_take_reti, w_is_nmi, w_is_irq, w_sr_wr;
    logic [15:0] w_code;
    logic [31:0] w_pc;
    logic        w_fe_entry, w_ei_entry;
    logic [3:0]  w_irq_next_i;
    logic [31:0] w_psw_entry;

`ifdef V810_ADTRE_EN
    logic [31:0] r_adtre;
    assign w_atrap = r_psw[c_PSW_AE] & (bus.fetch_pc == r_adtre);
`else
    logic w_unused_fetch;
    assign w_unused_fetch = ^bus.fetch_pc;
    assign w_atrap        = 1'b0;
`endif

    // A rising NMI edge is remembered until the sequencer can take it
    assign w_nmi_pend = r_nmi_pend | (bus.nmi & ~r_nmi_prev);

    assign w_irq_ok = bus.irq_req & ~r_psw[c_PSW_ID] & ~r_psw[c_PSW_EP] &
                      ~r_psw[c_PSW_NP] & (bus.irq_lvl >= r_psw[19:16]);

    assign w_irq_next_i = (bus.irq_lvl == 4'hF) ? 4'hF : bus.irq_lvl + 4'd1;

    // Next-state and event arbitration
    always_comb begin
        w_state_nxt = r_state;
        w_take_exc  = 1'b0;
        w_take_reti = 1'b0;
        w_is_nmi    = 1'b0;
        w_is_irq    = 1'b0;
        w_sr_wr     = 1'b0;
        w_code      = 16'h0000;
        w_pc        = 32'h0000_0000;
        case (r_state)
            ST_IDLE: begin
                if (bus.exc_req) begin
                    w_take_exc = 1'b1;
                    w_code     = bus.exc_code;
                    w_pc       = bus.exc_pc;
                end else if (w_atrap) begin
                    w_take_exc = 1'b1;
                    w_code     = 16'hFFC0;
                    w_pc       = bus.fetch_pc;
                end else if (w_nmi_pend) begin
                    w_take_exc = 1'b1;
                    w_is_nmi   = 1'b1;
                    w_code     = 16'hFFD0;
                    w_pc       = bus.cur_pc;
                end else if (w_irq_ok) begin
                    w_take_exc = 1'b1;
                    w_is_irq   = 1'b1;
                    w_code     = {8'hFE, bus.irq_lvl, 4'h0};
                    w_pc       = bus.cur_pc;
                end else if (bus.reti) begin
                    w_take_reti = 1'b1;
                end
                if (w_take_exc) begin
                    w_state_nxt = r_psw[c_PSW_NP] ? ST_FATAL : ST_REDIRECT;
                end else if (w_take_reti) begin
                    w_state_nxt = ST_REDIRECT;
                end else begin
                    w_sr_wr = bus.sr_we;
                end
            end
            ST_REDIRECT: begin
                if (bus.redirect_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FATAL: begin
                w_state_nxt = ST_FATAL;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Entry on an already-duplexed exception (NP=1) updates nothing
    assign w_fe_entry = w_take_exc & ~r_psw[c_PSW_NP] & (r_psw[c_PSW_EP] | w_is_nmi);
    assign w_ei_entry = w_take_exc & ~r_psw[c_PSW_NP] & ~r_psw[c_PSW_EP] & ~w_is_nmi;

    always_comb begin
        w_psw_entry            = r_psw;
        w_psw_entry[c_PSW_ID]  = 1'b1;
        w_psw_entry[c_PSW_AE]  = 1'b0;
        if (w_fe_entry) begin
            w_psw_entry[c_PSW_NP] = 1'b1;
        end else begin
            w_psw_entry[c_PSW_EP] = 1'b1;
            if (w_is_irq) begin
                w_psw_entry[19:16] = w_irq_next_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eipc        <= 32'h0000_0000;
            r_eipsw       <= 32'h0000_0000;
            r_fepc        <= 32'h0000_0000;
            r_fepsw       <= 32'h0000_0000;
            r_ecr         <= 32'h0000_FFF0;
            r_psw         <= 32'h0000_8000;
            r_chcw        <= 32'h0000_0000;
            r_redirect_pc <= 32'hFFFF_FFF0;
            r_nmi_prev    <= 1'b0;
            r_nmi_pend    <= 1'b0;
`ifdef V810_ADTRE_EN
            r_adtre       <= 32'h0000_0000;
`endif
        end else begin
            r_nmi_prev <= bus.nmi;
            r_nmi_pend <= w_nmi_pend & ~w_is_nmi;
            if (w_fe_entry) begin
                r_fepc        <= w_pc;
                r_fepsw       <= r_psw;
                r_ecr[31:16]  <= w_code;
                r_psw         <= w_psw_entry;
                r_redirect_pc <= c_DUP_VEC;
            end else if (w_ei_entry) begin
                r_eipc        <= w_pc;
                r_eipsw       <= r_psw;
                r_ecr[15:0]   <= w_code;
                r_psw         <= w_psw_entry;
                r_redirect_pc <= {16'hFFFF, w_code[15:4], 4'h0};
            end else if (w_take_reti) begin
                r_redirect_pc <= r_psw[c_PSW_NP] ? r_fepc  : r_eipc;
                r_psw         <= r_psw[c_PSW_NP] ? r_fepsw : r_eipsw;
            end else if (w_sr_wr) begin
                case (bus.sr_sel)
                    SR_EIPC:  r_eipc  <= {bus.sr_wdata[31:1], 1'b0};
                    SR_EIPSW: r_eipsw <= bus.sr_wdata;
                    SR_FEPC:  r_fepc  <= {bus.sr_wdata[31:1], 1'b0};
                    SR_FEPSW: r_fepsw <= bus.sr_wdata;
                    SR_PSW:   r_psw   <= bus.sr_wdata & c_PSW_MASK;
                    SR_CHCW:  r_chcw  <= bus.sr_wdata;
`ifdef V810_ADTRE_EN
                    SR_ADTRE: r_adtre <= {bus.sr_wdata[31:1], 1'b0};
`endif
                    default: ;
                endcase
            end
        end
    end

    // STSR read path: pre-write register state
    always_comb begin
        bus.sr_rdata = 32'h0000_0000;
        case (bus.sr_sel)
            SR_EIPC:  bus.sr_rdata = r_eipc;
            SR_EIPSW: bus.sr_rdata = r_eipsw;
            SR_FEPC:  bus.sr_rdata = r_fepc;
            SR_FEPSW: bus.sr_rdata = r_fepsw;
            SR_ECR:   bus.sr_rdata = r_ecr;
            SR_PSW:   bus.sr_rdata = r_psw;
            SR_PIR:   bus.sr_rdata = PIR_VALUE;
            SR_TKCW:  bus.sr_rdata = TKCW_VALUE;
            SR_CHCW:  bus.sr_rdata = r_chcw;
`ifdef V810_ADTRE_EN
            SR_ADTRE: bus.sr_rdata = r_adtre;
`endif
            default:  bus.sr_rdata = 32'h0000_0000;
        endcase
    end

    assign bus.redirect_valid = (r_state == ST_REDIRECT);
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.halt           = (r_state == ST_FATAL);
    assign bus.psw            = r_psw;

endmodule
`default_nettype wire

// File: tb/tb_v810_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_v810_exc_ctrl
// Purpose  : Directed self-checking bench for v810_exc_ctrl. Expected values
//            are hand-computed from the register and vector definitions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v810_exc_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    v810_exc_ctrl_if bus();

    v810_exc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.exc_req      = 1'b0;
        bus.exc_code     = 16'h0000;
        bus.exc_pc       = 32'h0;
        bus.cur_pc       = 32'h0;
        bus.nmi          = 1'b0;
        bus.irq_req      = 1'b0;
        bus.irq_lvl      = 4'h0;
        bus.reti         = 1'b0;
        bus.fetch_pc     = 32'h0;
        bus.redirect_ack = 1'b0;
        bus.sr_sel       = 5'd0;
        bus.sr_we        = 1'b0;
        bus.sr_wdata     = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic ldsr(input logic [4:0] sel, input logic [31:0] data);
        bus.sr_sel   = sel;
        bus.sr_wdata = data;
        bus.sr_we    = 1'b1;
        cyc();
        bus.sr_we    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.sr_sel = 5'd5; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_8000) begin n_err++; $display("FAIL reset_psw: got %h want %h", bus.sr_rdata, 32'h0000_8000); end
        bus.sr_sel = 5'd4; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_FFF0) begin n_err++; $display("FAIL reset_ecr: got %h want %h", bus.sr_rdata, 32'h0000_FFF0); end
        bus.sr_sel = 5'd6; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_8100) begin n_err++; $display("FAIL reset_pir: got %h want %h", bus.sr_rdata, 32'h0000_8100); end
        bus.sr_sel = 5'd7; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_00E0) begin n_err++; $display("FAIL reset_tkcw: got %h want %h", bus.sr_rdata, 32'h0000_00E0); end
        n_cmp++; if (bus.halt !== 1'b0) begin n_err++; $display("FAIL reset_halt: got %b want 0", bus.halt); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_busy_valid: got %b%b want 00", bus.busy, bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL reset_rpc: got %h want %h", bus.redirect_pc, 32'hFFFF_FFF0); end
    endtask

    task automatic test_irq_entry();
        ldsr(5'd5, 32'h0);
        n_cmp++; if (bus.psw !== 32'h0) begin n_err++; $display("FAIL ldsr_psw0: got %h want 0", bus.psw); end
        bus.irq_req = 1'b1;
        bus.irq_lvl = 4'd3;
        bus.cur_pc  = 32'h0700_0010;
        cyc();
        bus.irq_req = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("FAIL irq_valid: got %b want 1", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'hFFFF_FE30) begin n_err++; $display("FAIL irq_vec: got %h want %h", bus.redirect_pc, 32'hFFFF_FE30); end
        bus.sr_sel = 5'd0; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0700_0010) begin n_err++; $display("FAIL irq_eipc: got %h want %h", bus.sr_rdata, 32'h0700_0010); end
        bus.sr_sel = 5'd4; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_FE30) begin n_err++; $display("FAIL irq_ecr: got %h want %h", bus.sr_rdata, 32'h0000_FE30); end
        n_cmp++; if (bus.psw !== 32'h0004_5000) begin n_err++; $display("FAIL irq_psw: got %h want %h", bus.psw, 32'h0004_5000); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hFFFF_FE30 || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL irq_hold%0d: got v=%b pc=%h busy=%b want v=1 pc=FFFFFE30 busy=1", i, bus.redirect_valid, bus.redirect_pc, bus.busy);
            end
        end
        bus.redirect_ack = 1'b1;
        cyc();
        bus.redirect_ack = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL irq_ack: got v=%b busy=%b want 0 0", bus.redirect_valid, bus.busy); end
    endtask

    task automatic test_reti();
        bus.reti = 1'b1;
        cyc();
        bus.reti = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0700_0010) begin n_err++; $display("FAIL reti_pc: got v=%b pc=%h want v=1 pc=07000010", bus.redirect_valid, bus.redirect_pc); end
        n_cmp++; if (bus.psw !== 32'h0) begin n_err++; $display("FAIL reti_psw: got %h want 0", bus.psw); end
        bus.redirect_ack = 1'b1;
        cyc();
        bus.redirect_ack = 1'b0;
    endtask

    task automatic test_dup_and_fatal();
        do_reset();
        ldsr(5'd5, 32'h0000_4000);
        bus.exc_req  = 1'b1;
        bus.exc_code = 16'hFF60;
        bus.exc_pc   = 32'h0000_1234;
        cyc();
        bus.exc_req  = 1'b0;
        bus.sr_sel = 5'd2; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_1234) begin n_err++; $display("FAIL dup_fepc: got %h want %h", bus.sr_rdata, 32'h0000_1234); end
        bus.sr_sel = 5'd4; #1;
        n_cmp++; if (bus.sr_rdata !== 32'hFF60_FFF0) begin n_err++; $display("FAIL dup_ecr: got %h want %h", bus.sr_rdata, 32'hFF60_FFF0); end
        bus.sr_sel = 5'd3; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_4000) begin n_err++; $display("FAIL dup_fepsw: got %h want %h", bus.sr_rdata, 32'h0000_4000); end
        n_cmp++; if (bus.psw !== 32'h0000_D000) begin n_err++; $display("FAIL dup_psw: got %h want %h", bus.psw, 32'h0000_D000); end
        n_cmp++; if (bus.redirect_pc !== 32'hFFFF_FFD0) begin n_err++; $display("FAIL dup_vec: got %h want %h", bus.redirect_pc, 32'hFFFF_FFD0); end
        bus.redirect_ack = 1'b1;
        cyc();
        bus.redirect_ack = 1'b0;
        bus.exc_req  = 1'b1;
        bus.exc_pc   = 32'h0000_5678;
        cyc();
        bus.exc_req  = 1'b0;
        n_cmp++; if (bus.halt !== 1'b1 || bus.busy !== 1'b1 || bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL fatal_state: got h=%b b=%b v=%b want 1 1 0", bus.halt, bus.busy, bus.redirect_valid); end
        bus.sr_sel = 5'd2; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_1234 || bus.psw !== 32'h0000_D000) begin n_err++; $display("FAIL fatal_noupd: got fepc=%h psw=%h want 00001234 0000D000", bus.sr_rdata, bus.psw); end
        bus.redirect_ack = 1'b1;
        bus.reti         = 1'b1;
        cyc();
        cyc();
        bus.redirect_ack = 1'b0;
        bus.reti         = 1'b0;
        n_cmp++; if (bus.halt !== 1'b1) begin n_err++; $display("FAIL fatal_sticky: got %b want 1", bus.halt); end
        do_reset();
        n_cmp++; if (bus.halt !== 1'b0) begin n_err++; $display("FAIL fatal_rst: got %b want 0", bus.halt); end
    endtask

    task automatic test_priority();
        do_reset();
        ldsr(5'd5, 32'h0);
        bus.exc_req  = 1'b1;
        bus.exc_code = 16'hFF60;
        bus.exc_pc   = 32'h0000_0100;
        bus.nmi      = 1'b1;
        bus.irq_req  = 1'b1;
        bus.irq_lvl  = 4'd5;
        bus.cur_pc   = 32'h0000_0200;
        cyc();
        bus.exc_req  = 1'b0;
        n_cmp++; if (bus.redirect_pc !== 32'hFFFF_FF60 || bus.redirect_valid !== 1'b1) begin n_err++; $display("FAIL prio_exc_vec: got v=%b pc=%h want v=1 pc=FFFFFF60", bus.redirect_valid, bus.redirect_pc); end
        bus.sr_sel = 5'd0; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_0100 || bus.psw !== 32'h0000_5000) begin n_err++; $display("FAIL prio_exc_regs: got eipc=%h psw=%h want 00000100 00005000", bus.sr_rdata, bus.psw); end
        bus.redirect_ack = 1'b1;
        cyc();
        bus.redirect_ack = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL prio_idle: got %b want 0", bus.busy); end
        cyc();
        n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hFFFF_FFD0) begin n_err++; $display("FAIL prio_nmi_vec: got v=%b pc=%h want v=1 pc=FFFFFFD0", bus.redirect_valid, bus.redirect_pc); end
        bus.sr_sel = 5'd2; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_0200) begin n_err++; $display("FAIL prio_nmi_fepc: got %h want %h", bus.sr_rdata, 32'h0000_0200); end
        bus.sr_sel = 5'd4; #1;
        n_cmp++; if (bus.sr_rdata !== 32'hFFD0_FF60) begin n_err++; $display("FAIL prio_nmi_ecr: got %h want %h", bus.sr_rdata, 32'hFFD0_FF60); end
        bus.sr_sel = 5'd3; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_5000 || bus.psw !== 32'h0000_D000) begin n_err++; $display("FAIL prio_nmi_psw: got fepsw=%h psw=%h want 00005000 0000D000", bus.sr_rdata, bus.psw); end
        bus.redirect_ack = 1'b1;
        cyc();
        bus.redirect_ack = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL prio_irq_blocked: got v=%b busy=%b want 0 0", bus.redirect_valid, bus.busy); end
        clear_inputs();
    endtask

    task automatic test_mask_and_async_rst();
        do_reset();
        ldsr(5'd5, 32'hFFFF_FFFF);
        bus.sr_sel = 5'd5; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h000F_F3FF || bus.psw !== 32'h000F_F3FF) begin n_err++; $display("FAIL psw_mask: got rd=%h psw=%h want 000FF3FF", bus.sr_rdata, bus.psw); end
        ldsr(5'd0, 32'h0000_1235);
        bus.sr_sel = 5'd0; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_1234) begin n_err++; $display("FAIL eipc_bit0: got %h want %h", bus.sr_rdata, 32'h0000_1234); end
        ldsr(5'd4, 32'h0);
        bus.sr_sel = 5'd4; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0000_FFF0) begin n_err++; $display("FAIL ecr_ro: got %h want %h", bus.sr_rdata, 32'h0000_FFF0); end
        ldsr(5'd10, 32'hDEAD_BEEF);
        bus.sr_sel = 5'd10; #1;
        n_cmp++; if (bus.sr_rdata !== 32'h0) begin n_err++; $display("FAIL unlisted_rd: got %h want 0", bus.sr_rdata); end
        ldsr(5'd2, 32'h0000_0ABC);
        bus.reti = 1'b1;
        cyc();
        bus.reti = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0000_0ABC) begin n_err++; $display("FAIL reti_np: got v=%b pc=%h want v=1 pc=00000ABC", bus.redirect_valid, bus.redirect_pc); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0 || bus.redirect_pc !== 32'hFFFF_FFF0 || bus.psw !== 32'h0000_8000) begin
            n_err++;
            $display("FAIL async_rst: got v=%b b=%b pc=%h psw=%h want 0 0 FFFFFFF0 00008000", bus.redirect_valid, bus.busy, bus.redirect_pc, bus.psw);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_irq_entry();
        test_reti();
        test_dup_and_fatal();
        test_priority();
        test_mask_and_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
